uart_sync_fifo: RTL and testbench

// - Parametrised synchronous FIFO for the UART TX/RX datapath. Successor of the fixed 16-byte TX FIFO.
// - Adds arbitrary depth and true full/empty with a DEPTH+1-state level.
// - Adds simultaneous read+write, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// - Sits between the bus register interface (write side) and the UART shifter (read side, gated by hold_i).

---
 rtl/uart_sync_fifo.sv | 127 ++++++++++++
 tb/tb_uart_sync_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - parametrised UART datapath FIFO; optional first-word fall-through via UART_FIFO_FWFT_EN
module uart_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [LW-1:0]    level_o,
    output logic             ovf_o,
    output logic             udf_o
);

    // Pointer width; DEPTH need not be a power of two, so wrap is an explicit compare.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic             udf_q;
    logic             rd_acc;
    logic             wr_acc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Every status flag is a pure function of the registered level.
    assign empty_o        = (level_q == '0);
    assign full_o         = (level_q == LVL_FULL);
    assign almost_full_o  = (int'(level_q) >= AF_THRESH);
    assign almost_empty_o = (int'(level_q) <= AE_THRESH);
    assign level_o        = level_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

    // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
    assign rd_acc = re_i & ~empty_o & ~hold_i;
    assign wr_acc = we_i & (~full_o | rd_acc);

    // Pointers, level and sticky error flags; flush outranks any request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (rd_acc) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (we_i & ~wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (re_i & empty_o & ~hold_i) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk_i) begin
        if (wr_acc & ~clr_i) begin
            mem[wptr_q] <= wdata_i;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head word is presented combinationally whenever the FIFO holds data.
    assign rdata_o  = empty_o ? '0 : mem[rptr_q];
    assign rvalid_o = ~empty_o;
`else
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // Registered read: data captured on the accepting edge, valid pulses for one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (clr_i) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= mem[rptr_q];
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb/tb_uart_sync_fifo.sv - randomized and directed self-checking bench for uart_sync_fifo
module tb_uart_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we [2];
    logic       re [2];
    logic       hold [2];
    logic       clr [2];
    logic [7:0] wd [2];

    logic [7:0] o_rdata [2];
    logic       o_rv [2];
    logic       o_full [2];
    logic       o_empty [2];
    logic       o_af [2];
    logic       o_ae [2];
    logic       o_ovf [2];
    logic       o_udf [2];
    logic [4:0] lvl0;
    logic [2:0] lvl1;

    int         n_chk = 0;
    int         n_pass = 0;

    // reference model: one word queue per instance plus sticky flags
    int         dep [2] = '{16, 5};
    int         mq [2][$];
    bit         movf [2];
    bit         mudf [2];
    bit         mrv [2];
    int         mrd [2];

    always #5 clk = ~clk;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(16)) u_fifo16 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr[0]), .we_i(we[0]), .wdata_i(wd[0]),
        .re_i(re[0]), .hold_i(hold[0]), .rdata_o(o_rdata[0]), .rvalid_o(o_rv[0]),
        .full_o(o_full[0]), .empty_o(o_empty[0]), .almost_full_o(o_af[0]),
        .almost_empty_o(o_ae[0]), .level_o(lvl0), .ovf_o(o_ovf[0]), .udf_o(o_udf[0])
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(5)) u_fifo5 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr[1]), .we_i(we[1]), .wdata_i(wd[1]),
        .re_i(re[1]), .hold_i(hold[1]), .rdata_o(o_rdata[1]), .rvalid_o(o_rv[1]),
        .full_o(o_full[1]), .empty_o(o_empty[1]), .almost_full_o(o_af[1]),
        .almost_empty_o(o_ae[1]), .level_o(lvl1), .ovf_o(o_ovf[1]), .udf_o(o_udf[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            we[k] = 0; re[k] = 0; hold[k] = 0; clr[k] = 0; wd[k] = 8'h00;
        end
    endtask

    task automatic drive(input int k, input bit w, input int d, input bit r, input bit h, input bit c);
        we[k] = w; wd[k] = d[7:0]; re[k] = r; hold[k] = h; clr[k] = c;
    endtask

    task automatic model_reset(input int k);
        mq[k].delete();
        movf[k] = 0; mudf[k] = 0; mrv[k] = 0; mrd[k] = 0;
    endtask

    // advance the model by one clock edge using the inputs now applied
    task automatic model_step(input int k);
        int  sz;
        bit  rd, wr;
        sz = mq[k].size();
        if (clr[k]) begin
            mq[k].delete();
            movf[k] = 0; mudf[k] = 0; mrv[k] = 0;
        end else begin
            rd = re[k] && (sz > 0) && !hold[k];
            wr = we[k] && ((sz < dep[k]) || rd);
            mrv[k] = rd;
            if (rd) mrd[k] = mq[k].pop_front();
            if (wr) mq[k].push_back(int'(wd[k]));
            if (we[k] && !wr) movf[k] = 1;
            if (re[k] && (sz == 0) && !hold[k]) mudf[k] = 1;
        end
    endtask

    task automatic compare_all(input int k, input string ph);
        int sz;
        int lvl;
        sz  = mq[k].size();
        lvl = (k == 0) ? int'(lvl0) : int'(lvl1);
        check($sformatf("%s%0d_level", ph, k), lvl, sz);
        check($sformatf("%s%0d_empty", ph, k), o_empty[k], sz == 0);
        check($sformatf("%s%0d_full", ph, k), o_full[k], sz == dep[k]);
        check($sformatf("%s%0d_afull", ph, k), o_af[k], sz >= dep[k] - 2);
        check($sformatf("%s%0d_aempty", ph, k), o_ae[k], sz <= 1);
        check($sformatf("%s%0d_ovf", ph, k), o_ovf[k], movf[k]);
        check($sformatf("%s%0d_udf", ph, k), o_udf[k], mudf[k]);
`ifdef UART_FIFO_FWFT_EN
        check($sformatf("%s%0d_rvalid", ph, k), o_rv[k], sz > 0);
        check($sformatf("%s%0d_rdata", ph, k), o_rdata[k], (sz > 0) ? mq[k][0] : 0);
`else
        check($sformatf("%s%0d_rvalid", ph, k), o_rv[k], mrv[k]);
        check($sformatf("%s%0d_rdata", ph, k), o_rdata[k], mrd[k]);
`endif
    endtask

    // one clock: model update, edge, compare #1 later, return at next falling edge with idle inputs
    task automatic step();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) compare_all(k, "cyc");
        @(negedge clk);
        clear_inputs();
    endtask

    // asynchronous reset, checked before any clock edge can occur
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            compare_all(k, "rst");
            check($sformatf("rst%0d_empty_const", k), o_empty[k], 1);
            check($sformatf("rst%0d_rvalid_const", k), o_rv[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        int pw, pr;
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // fill and overflow
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, 0, 0, 0);
            step();
            check("t1_afull", o_af[0], i >= 13);
        end
        check("t1_full", o_full[0], 1);
        drive(0, 1, 8'hAA, 0, 0, 0);
        step();
        check("t1_ovf", o_ovf[0], 1);
        check("t1_level", lvl0, 16);

        // drain and underflow
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            step();
`ifndef UART_FIFO_FWFT_EN
            check("t2_rdata", o_rdata[0], i);
            check("t2_rvalid", o_rv[0], 1);
`endif
        end
        check("t2_empty", o_empty[0], 1);
        drive(0, 0, 0, 1, 0, 0);
        step();
        check("t2_udf", o_udf[0], 1);
`ifndef UART_FIFO_FWFT_EN
        check("t2_rvalid_udf", o_rv[0], 0);
`endif

        // simultaneous read+write at level 5 and at full
        drive(0, 0, 0, 0, 0, 1); step();
        for (int i = 0; i < 5; i++) begin drive(0, 1, 8'h30 + i, 0, 0, 0); step(); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'h40 + i, 1, 0, 0); step();
            check("t3_level5", lvl0, 5);
        end
        for (int i = 0; i < 11; i++) begin drive(0, 1, 8'h50 + i, 0, 0, 0); step(); end
        drive(0, 1, 8'h77, 1, 0, 0); step();
        check("t3_full_level", lvl0, 16);
        check("t3_full_ovf", o_ovf[0], 0);
        for (int i = 0; i < 16; i++) begin drive(0, 0, 0, 1, 0, 0); step(); end

        // hold blocks reads
        for (int i = 0; i < 3; i++) begin drive(0, 1, 8'h60 + i, 0, 0, 0); step(); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 0); step();
            check("t4_hold_level", lvl0, 3);
        end
        drive(0, 0, 0, 1, 0, 0); step();
        check("t4_release_level", lvl0, 2);

        // flush with write at level 7 and overflow set
        drive(0, 0, 0, 0, 0, 1); step();
        for (int i = 0; i < 17; i++) begin drive(0, 1, 8'h80 + i, 0, 0, 0); step(); end
        for (int i = 0; i < 9; i++) begin drive(0, 0, 0, 1, 0, 0); step(); end
        check("t6_pre_level", lvl0, 7);
        check("t6_pre_ovf", o_ovf[0], 1);
        drive(0, 1, 8'hEE, 0, 0, 1); step();
        check("t6_clr_level", lvl0, 0);
        check("t6_clr_ovf", o_ovf[0], 0);

        // wrap-around on the 5-deep instance, 0x10..0x23
        for (int i = 0; i < 3; i++) begin drive(1, 1, 8'h10 + i, 0, 0, 0); step(); end
        for (int i = 3; i < 20; i++) begin
            drive(1, 1, 8'h10 + i, 1, 0, 0); step();
            check("t5_level", lvl1, 3);
        end
        for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 1, 0, 0); step(); end

        // randomized traffic with varying write/read bias on both instances
        for (int n = 0; n < 3000; n++) begin
            pw = ((n / 300) % 2 == 0) ? 70 : 30;
            pr = 100 - pw;
            for (int k = 0; k < 2; k++) begin
                drive(k, $urandom_range(99) < pw, $urandom_range(255),
                      $urandom_range(99) < pr, $urandom_range(99) < 15,
                      $urandom_range(999) < 8);
            end
            step();
        end

        // reset asserted mid-burst
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'hC0 + i, 1, 0, 0);
            drive(1, 1, 8'hD0 + i, 0, 0, 0);
            step();
        end
        drive(0, 1, 8'hCF, 1, 0, 0);
        drive(1, 1, 8'hDF, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(0, 1, 8'hF0 + i, 0, 0, 0); step(); end
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0, 0); step(); end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
